// File: rtl/ld_wb_stall_seq_pkg.sv
// Shared types and constants for the load-use stall sequencer.
// The opcode constant is also used by decode and the hazard unit.
package ld_wb_stall_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } seq_state_e;

    localparam logic [3:0] RegZero = 4'd0;
    localparam logic [3:0] OpLoad  = 4'b1000;

endpackage

// File: rtl/ld_wb_stall_seq_if.sv
// Stall interface between the hazard unit / pipeline (master) and the stall sequencer (slave).
interface ld_wb_stall_seq_if #(
    parameter int unsigned CNT_W = 8
);
    logic             stall_req;
    logic [3:0]       e_wreg;
    logic [3:0]       w_wreg;
    logic             w_we;
    logic             flush;
    logic             write_done;
    logic             nop_inject;
    logic             busy;
    logic [3:0]       held_wreg;
    logic             stall_err;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output stall_req, e_wreg, w_wreg, w_we, flush,
        input  write_done, nop_inject, busy, held_wreg, stall_err, bubble_cnt
    );

    modport slave (
        input  stall_req, e_wreg, w_wreg, w_we, flush,
        output write_done, nop_inject, busy, held_wreg, stall_err, bubble_cnt
    );
endinterface

// File: rtl/ld_wb_stall_seq_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module ld_wb_stall_seq_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [Width-1:0] count
);
    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else if (en && (count_q != '1)) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign count = count_q;
endmodule

// File: rtl/ld_wb_stall_seq.sv
// Load-use stall sequencer: holds a stalling load's destination until writeback,
// injects bubbles meanwhile and pulses write_done to release the hazard unit.
module ld_wb_stall_seq
    import ld_wb_stall_seq_pkg::*;
#(
    parameter int unsigned MAX_STALL = 8,
    parameter int unsigned CNT_W     = 8
) (
    input logic             clk,
    input logic             rst_n,
    ld_wb_stall_seq_if.slave bus
);
    localparam int unsigned WaitW = $clog2(MAX_STALL + 1);

    seq_state_e       state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [3:0]       held_q, held_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        held_d  = held_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                // Loads to r0 never write anything, so there is nothing to wait for.
                if (bus.stall_req && (bus.e_wreg != RegZero)) begin
                    held_d  = bus.e_wreg;
                    wait_d  = WaitW'(1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (bus.w_we && (bus.w_wreg == held_q)) begin
                    state_d = StDone;
                end else if (wait_q == WaitW'(MAX_STALL)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (!bus.stall_req) begin
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wait_q  <= '0;
            held_q  <= RegZero;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            held_q  <= held_d;
            err_q   <= err_d;
        end
    end

    assign bus.write_done = (state_q == StDone);
    assign bus.busy       = (state_q != StIdle);
    assign bus.held_wreg  = held_q;
    assign bus.stall_err  = err_q;
    // No bubble on the release cycle: the dependent instruction proceeds.
    assign bus.nop_inject = bus.stall_req && (state_q != StDone);

    ld_wb_stall_seq_sat_counter #(
        .Width (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (bus.nop_inject),
        .count (bus.bubble_cnt)
    );
endmodule
